// File: rtl/ring_osc_pkg.sv
// Shared state encodings and trim helpers for the ring oscillator trim loop.
package ring_osc_pkg;

    localparam int MAX_STAGES = 32;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_MEASURE = 3'd2;
    localparam logic [2:0] ST_ADJUST  = 3'd3;
    localparam logic [2:0] ST_LOCKED  = 3'd4;

    function automatic int lw_of(input int nstage);
        return $clog2(2 * nstage + 1);
    endfunction

    // Thermometer code: primaries fill first, secondaries only once every primary is set.
    function automatic logic [2*MAX_STAGES-1:0] lvl2trim(input int level, input int nstage);
        logic [2*MAX_STAGES-1:0] vec;
        vec = '0;
        for (int i = 0; i < MAX_STAGES; i++) begin
            if (i < nstage) begin
                vec[i]          = (level > i);
                vec[nstage + i] = (level > nstage + i);
            end
        end
        return vec;
    endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Brings the divided oscillator toggle into clk and flags each toggle edge once.
module osc_edge_sync (
    input  logic clk,
    input  logic resetn,
    input  logic osc_tgl,
    output logic edge_pulse
);

    logic [2:0] sync_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], osc_tgl};
        end
    end

    // Bits 0 and 1 form the synchronizer; bit 2 is the history flop for edge detection.
    assign edge_pulse = sync_reg[1] ^ sync_reg[2];

endmodule

// File: rtl/ring_osc_trim_ctrl.sv
// Closed-loop trim controller: steps the oscillator trim level until the
// measured edge count per window sits inside target +/- tol.
module ring_osc_trim_ctrl
    import ring_osc_pkg::*;
#(
    parameter int NSTAGE     = 13,
    parameter int WIN_LOG2   = 10,
    parameter int CNT_W      = 12,
    parameter int SETTLE_CYC = 16,
    parameter int LW         = lw_of(NSTAGE)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                auto,
    input  logic [LW-1:0]       man_level,
    input  logic [CNT_W-1:0]    target,
    input  logic [CNT_W-1:0]    tol,
    input  logic                osc_tgl,
    output logic [2*NSTAGE-1:0] trim,
    output logic [LW-1:0]       trim_level,
    output logic [CNT_W-1:0]    meas_count,
    output logic                locked,
    output logic                busy,
    output logic                sat_hi,
    output logic                sat_lo
);

    localparam int TW = 2 * NSTAGE;
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [LW-1:0]    MAX_LVL     = LW'(TW);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic                edge_pulse;
    logic                run;
    logic [2:0]          state_reg, state_next;
    logic [SW-1:0]       settle_reg;
    logic [WIN_LOG2-1:0] win_reg;
    logic [CNT_W-1:0]    edge_cnt_reg, edge_cnt_inc;
    logic [LW-1:0]       level_reg, level_next;
    logic [CNT_W:0]      hi_bound, lo_bound;
    logic                too_fast, too_slow;

    osc_edge_sync edge_sync (
        .clk        (clk),
        .resetn     (resetn),
        .osc_tgl    (osc_tgl),
        .edge_pulse (edge_pulse)
    );

    assign run = enable & auto;

    // One extra bit keeps target+tol and target-tol from wrapping.
    always_comb begin
        hi_bound     = {1'b0, target} + {1'b0, tol};
        lo_bound     = {1'b0, target} - {1'b0, tol};
        too_fast     = ({1'b0, meas_count} > hi_bound);
        too_slow     = (target >= tol) && ({1'b0, meas_count} < lo_bound);
        edge_cnt_inc = (edge_pulse && (edge_cnt_reg != CNT_MAX)) ? edge_cnt_reg + 1'b1 : edge_cnt_reg;
    end

    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        if (!run) begin
            state_next = ST_IDLE;
            level_next = (man_level > MAX_LVL) ? MAX_LVL : man_level;
        end else begin
            case (state_reg)
                ST_IDLE:    state_next = ST_SETTLE;
                ST_SETTLE:  if (settle_reg == SETTLE_LAST) state_next = ST_MEASURE;
                ST_MEASURE: if (&win_reg) state_next = ST_ADJUST;
                ST_ADJUST: begin
                    if (too_fast) begin
                        state_next = ST_SETTLE;
                        if (level_reg != MAX_LVL) level_next = level_reg + 1'b1;
                    end else if (too_slow) begin
                        state_next = ST_SETTLE;
                        if (level_reg != '0) level_next = level_reg - 1'b1;
                    end else begin
                        state_next = ST_LOCKED;
                    end
                end
                ST_LOCKED:  state_next = ST_MEASURE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            settle_reg   <= '0;
            win_reg      <= '0;
            edge_cnt_reg <= '0;
            level_reg    <= '0;
            trim         <= '0;
            meas_count   <= '0;
            locked       <= 1'b0;
            busy         <= 1'b0;
            sat_hi       <= 1'b0;
            sat_lo       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            level_reg    <= level_next;
            trim         <= TW'(lvl2trim(int'(level_next), NSTAGE));
            busy         <= (state_reg != ST_IDLE);
            // Counters idle at zero outside their state, so each window starts clean.
            settle_reg   <= (state_reg == ST_SETTLE)  ? settle_reg + 1'b1 : '0;
            win_reg      <= (state_reg == ST_MEASURE) ? win_reg + 1'b1    : '0;
            edge_cnt_reg <= (state_reg == ST_MEASURE) ? edge_cnt_inc      : '0;

            if (run && (state_reg == ST_MEASURE) && (&win_reg)) begin
                meas_count <= edge_cnt_inc;
            end

            if (!run) begin
                locked <= 1'b0;
            end else if (state_reg == ST_ADJUST) begin
                if (too_fast) begin
                    locked <= 1'b0;
                    sat_hi <= (level_reg == MAX_LVL);
                end else if (too_slow) begin
                    locked <= 1'b0;
                    sat_lo <= (level_reg == '0);
                end else begin
                    locked <= 1'b1;
                    sat_hi <= 1'b0;
                    sat_lo <= 1'b0;
                end
            end
        end
    end

    assign trim_level = level_reg;

endmodule

// File: tb/tb_ring_osc_trim_ctrl.sv
// Directed bench for ring_osc_trim_ctrl with a rate-accurate oscillator model.
module tb_ring_osc_trim_ctrl;

    localparam int NSTAGE     = 13;
    localparam int WIN_LOG2   = 11;
    localparam int CNT_W      = 12;
    localparam int SETTLE_CYC = 16;
    localparam int LW         = 5;
    localparam int TW         = 2 * NSTAGE;
    localparam int WIN        = 1 << WIN_LOG2;
    localparam int STEP       = 1 + SETTLE_CYC + WIN;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             enable = 1'b0;
    logic             auto = 1'b0;
    logic             osc_tgl = 1'b0;
    logic [LW-1:0]    man_level = '0;
    logic [CNT_W-1:0] target = '0;
    logic [CNT_W-1:0] tol = '0;
    logic [TW-1:0]    trim;
    logic [LW-1:0]    trim_level;
    logic [CNT_W-1:0] meas_count;
    logic             locked, busy, sat_hi, sat_lo;

    int n_checks = 0;
    int n_fail   = 0;
    int base      = 1000;
    bit stuck     = 1'b0;
    int stuck_val = 0;
    int acc       = 0;
    int osc_rate  = 0;

    always #5 clk = ~clk;

    ring_osc_trim_ctrl #(
        .NSTAGE     (NSTAGE),
        .WIN_LOG2   (WIN_LOG2),
        .CNT_W      (CNT_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .auto       (auto),
        .man_level  (man_level),
        .target     (target),
        .tol        (tol),
        .osc_tgl    (osc_tgl),
        .trim       (trim),
        .trim_level (trim_level),
        .meas_count (meas_count),
        .locked     (locked),
        .busy       (busy),
        .sat_hi     (sat_hi),
        .sat_lo     (sat_lo)
    );

    // Phase accumulator: any WIN consecutive cycles at a fixed rate hold exactly osc_rate toggles.
    always @(negedge clk) begin
        osc_rate = stuck ? stuck_val : base - 20 * $countones(trim);
        if (osc_rate < 0) osc_rate = 0;
        if (osc_rate > WIN - 1) osc_rate = WIN - 1;
        acc = acc + osc_rate;
        if (acc >= WIN) begin
            acc = acc - WIN;
            osc_tgl = ~osc_tgl;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0; enable = 1'b0; auto = 1'b0;
        tick(2);
        n_checks++; if (trim !== '0) begin n_fail++; $display("FAIL reset_trim got=%h want=0", trim); end
        n_checks++; if (trim_level !== '0) begin n_fail++; $display("FAIL reset_level got=%0d want=0", trim_level); end
        n_checks++; if (meas_count !== '0) begin n_fail++; $display("FAIL reset_meas got=%0d want=0", meas_count); end
        n_checks++; if ({locked, busy, sat_hi, sat_lo} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags got=%b want=0000", {locked, busy, sat_hi, sat_lo});
        end
        $display("reset: trim=%h level=%0d flags=%b", trim, trim_level, {locked, busy, sat_hi, sat_lo});
        resetn = 1'b1;
    endtask

    task automatic test_manual;
        logic [LW-1:0] lv [7] = '{5'd0, 5'd1, 5'd13, 5'd14, 5'd15, 5'd26, 5'd31};
        logic [LW-1:0] el [7] = '{5'd0, 5'd1, 5'd13, 5'd14, 5'd15, 5'd26, 5'd26};
        logic [TW-1:0] et [7] = '{26'h0, 26'h1, 26'h1FFF, 26'h3FFF, 26'h7FFF, 26'h3FFFFFF, 26'h3FFFFFF};
        enable = 1'b1; auto = 1'b0;
        for (int i = 0; i < 7; i++) begin
            man_level = lv[i];
            tick(1);
            n_checks++; if (trim !== et[i]) begin n_fail++; $display("FAIL manual_trim man=%0d got=%h want=%h", lv[i], trim, et[i]); end
            n_checks++; if (trim_level !== el[i]) begin n_fail++; $display("FAIL manual_level man=%0d got=%0d want=%0d", lv[i], trim_level, el[i]); end
            $display("manual: man_level=%0d trim=%h level=%0d", lv[i], trim, trim_level);
        end
    endtask

    task automatic test_lock_from_fast;
        int prev, steps, cyc, last_change, interval;
        bit done, bad;
        base = 1000; stuck = 1'b0; target = 12'd800; tol = 12'd5;
        man_level = '0; auto = 1'b0;
        tick(2);
        n_checks++; if (trim_level !== '0) begin n_fail++; $display("FAIL lock_start_level got=%0d want=0", trim_level); end
        auto = 1'b1;
        tick(1);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_lag got=%b want=0", busy); end
        tick(1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_rise got=%b want=1", busy); end
        prev = 0; steps = 0; cyc = 0; last_change = 0; interval = 0; done = 1'b0;
        for (int c = 0; c < 12 * STEP && !done; c++) begin
            tick(1);
            cyc++;
            if (int'(trim_level) != prev) begin
                n_checks++;
                if (trim_level !== LW'(prev + 1)) begin
                    n_fail++; $display("FAIL ramp_step got=%0d want=%0d", trim_level, prev + 1);
                end
                if (steps == 1) interval = cyc - last_change;
                last_change = cyc; steps++; prev = int'(trim_level);
            end
            if (locked === 1'b1) done = 1'b1;
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL lock_timeout got=locked0 want=locked1"); end
        n_checks++; if (trim_level !== 5'd10) begin n_fail++; $display("FAIL lock_level got=%0d want=10", trim_level); end
        n_checks++; if (meas_count !== 12'd800) begin n_fail++; $display("FAIL lock_meas got=%0d want=800", meas_count); end
        n_checks++; if (steps != 10) begin n_fail++; $display("FAIL lock_steps got=%0d want=10", steps); end
        n_checks++; if (interval != STEP) begin n_fail++; $display("FAIL step_period got=%0d want=%0d", interval, STEP); end
        $display("lock: level=%0d meas=%0d steps=%0d period=%0d", trim_level, meas_count, steps, interval);
        bad = 1'b0;
        for (int c = 0; c < 3 * (WIN + 2) + 5; c++) begin
            tick(1);
            if (trim_level !== 5'd10 || locked !== 1'b1) bad = 1'b1;
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL lock_hold got=level%0d/locked%b want=level10/locked1", trim_level, locked); end
        n_checks++; if (meas_count !== 12'd800) begin n_fail++; $display("FAIL hold_meas got=%0d want=800", meas_count); end
        $display("hold: level=%0d locked=%b meas=%0d", trim_level, locked, meas_count);
    endtask

    task automatic test_loss_of_lock;
        bit seen;
        base = 1050;
        seen = 1'b0;
        for (int c = 0; c < 3 * (WIN + 2) + 10 && !seen; c++) begin
            tick(1);
            if (locked === 1'b0) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL unlock_timeout got=locked1 want=locked0"); end
        n_checks++; if (trim_level !== 5'd11) begin n_fail++; $display("FAIL unlock_level got=%0d want=11", trim_level); end
        n_checks++; if (sat_hi !== 1'b0) begin n_fail++; $display("FAIL unlock_sat_hi got=%b want=0", sat_hi); end
        $display("unlock: level=%0d locked=%b meas=%0d", trim_level, locked, meas_count);
    endtask

    task automatic test_saturation;
        bit seen, over;
        stuck = 1'b1; stuck_val = 2000; target = 12'd100; tol = 12'd5;
        auto = 1'b0; man_level = 5'd22;
        tick(2);
        auto = 1'b1;
        seen = 1'b0; over = 1'b0;
        for (int c = 0; c < 8 * STEP && !seen; c++) begin
            tick(1);
            if (trim_level > 5'd26) over = 1'b1;
            if (sat_hi === 1'b1) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL sat_hi_timeout got=0 want=1"); end
        n_checks++; if (over) begin n_fail++; $display("FAIL sat_overrun got=level>26 want=level<=26"); end
        n_checks++; if (trim_level !== 5'd26) begin n_fail++; $display("FAIL sat_level got=%0d want=26", trim_level); end
        n_checks++; if (trim !== 26'h3FFFFFF) begin n_fail++; $display("FAIL sat_trim got=%h want=3ffffff", trim); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL sat_locked got=%b want=0", locked); end
        n_checks++; if (meas_count !== 12'd2000) begin n_fail++; $display("FAIL sat_meas got=%0d want=2000", meas_count); end
        tick(500);
        n_checks++; if (trim_level !== 5'd26 || sat_hi !== 1'b1) begin
            n_fail++; $display("FAIL sat_hold got=level%0d/sat%b want=level26/sat1", trim_level, sat_hi);
        end
        $display("saturation: level=%0d sat_hi=%b locked=%b meas=%0d", trim_level, sat_hi, locked, meas_count);
    endtask

    task automatic test_abort;
        man_level = 5'd7; enable = 1'b0;
        tick(1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_lag got=%b want=1", busy); end
        n_checks++; if (trim_level !== 5'd7) begin n_fail++; $display("FAIL abort_level got=%0d want=7", trim_level); end
        tick(1);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b want=0", busy); end
        n_checks++; if (meas_count !== 12'd2000) begin n_fail++; $display("FAIL abort_meas got=%0d want=2000", meas_count); end
        n_checks++; if (trim !== 26'h7F) begin n_fail++; $display("FAIL abort_trim got=%h want=7f", trim); end
        $display("abort: busy=%b level=%0d meas=%0d", busy, trim_level, meas_count);
    endtask

    task automatic test_reset_midrun;
        stuck_val = 0; target = 12'd100; tol = 12'd5;
        enable = 1'b1; auto = 1'b1;
        tick(100);
        resetn = 1'b0;
        tick(1);
        n_checks++; if (trim !== '0 || trim_level !== '0) begin
            n_fail++; $display("FAIL midrun_reset_trim got=%h/%0d want=0/0", trim, trim_level);
        end
        n_checks++; if (meas_count !== '0 || {locked, busy, sat_hi, sat_lo} !== 4'b0) begin
            n_fail++; $display("FAIL midrun_reset_flags got=%0d/%b want=0/0000", meas_count, {locked, busy, sat_hi, sat_lo});
        end
        $display("midrun reset: level=%0d flags=%b", trim_level, {locked, busy, sat_hi, sat_lo});
        tick(1);
        resetn = 1'b1;
    endtask

    task automatic test_sat_lo;
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 2 * STEP + 50 && !seen; c++) begin
            tick(1);
            if (sat_lo === 1'b1) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL sat_lo_timeout got=0 want=1"); end
        n_checks++; if (trim_level !== '0) begin n_fail++; $display("FAIL sat_lo_level got=%0d want=0", trim_level); end
        n_checks++; if (locked !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL sat_lo_flags got=%b%b want=01", locked, busy);
        end
        $display("sat_lo: level=%0d sat_lo=%b meas=%0d", trim_level, sat_lo, meas_count);
    endtask

    initial begin
        test_reset();
        test_manual();
        test_lock_from_fast();
        test_loss_of_lock();
        test_saturation();
        test_abort();
        test_reset_midrun();
        test_sat_lo();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_osc_trim_ctrl.md
# ring_osc_trim_ctrl

Closed-loop trim controller for the parametrised N-stage tunable ring oscillator. Counts edges from a pre-divided, free-running oscillator toggle over a fixed reference window. Steps the oscillator's non-binary trim vector one level at a time until the count sits within a tolerance band of a programmed target. Sits in the clocking block beside the oscillator; a manual mode passes a software trim level straight through.

## Interface
- NSTAGE, 13: oscillator stage count; the trim vector is 2*NSTAGE bits.
- WIN_LOG2, 10: measurement window is 2^WIN_LOG2 clk cycles.
- CNT_W, 12: edge-counter and target width.
- SETTLE_CYC, 16: clk cycles to wait after each trim change before measuring.
- LW: derived, $clog2(2*NSTAGE+1); trim level width.

- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- enable  in  1  controller enable
- auto  in  1  1 = closed-loop, 0 = manual
- man_level  in  LW  manual trim level
- target  in  CNT_W  desired edge count per window
- tol  in  CNT_W  allowed deviation from target
- osc_tgl  in  1  divided oscillator toggle, asynchronous to clk
- trim  out  2*NSTAGE  trim vector; bit i is primary trim of stage i, bit i+NSTAGE is secondary
- trim_level  out  LW  current level, 0..2*NSTAGE
- meas_count  out  CNT_W  last completed window count
- locked  out  1  last measurement was within band
- busy  out  1  FSM not in IDLE
- sat_hi  out  1  wanted slower at max level
- sat_lo  out  1  wanted faster at level 0

## Operation
- **Level-to-trim mapping (thermometer):**
  - Level L <= NSTAGE: primary bits trim[L-1:0] = 1, all others 0.
  - Level L > NSTAGE: all primary bits = 1, secondary bits trim[NSTAGE+L-NSTAGE-1:NSTAGE] = 1.
  - Secondary bits are never set before all primary bits are set. A higher level means a slower oscillator.
- **Edge detect:** osc_tgl passes through a 2-flop synchronizer. An edge is the XOR of the 2nd and 3rd flops; each toggle edge counts once. The edge counter saturates at 2^CNT_W-1.
- **States:** IDLE, SETTLE, MEASURE, ADJUST, LOCKED.
- **IDLE:**
  - Entered on reset, when enable=0, or when auto=0.
  - When enable=0 or auto=0: trim_level = min(man_level, 2*NSTAGE) and locked=0.
  - Exits to SETTLE when enable=1 and auto=1. The loop starts from the current level.
- **SETTLE:** counts SETTLE_CYC cycles, then goes to MEASURE with the edge counter cleared.
- **MEASURE:** counts edges for exactly 2^WIN_LOG2 cycles, latches meas_count, then goes to ADJUST.
- **ADJUST (one cycle), comparing meas_count (C) with target (T) and tol, using CNT_W+1-bit unsigned compares so T+tol cannot wrap:**
  - C > T+tol (too fast): if level < 2*NSTAGE, level+1, sat_hi=0, go to SETTLE. Otherwise set sat_hi, go to SETTLE with no change.
  - T >= tol and C < T-tol (too slow): if level > 0, level-1, sat_lo=0. Otherwise set sat_lo. Go to SETTLE.
  - Otherwise: locked=1, clear both sat flags, go to LOCKED.
- **LOCKED:** re-measures continuously (MEASURE, then ADJUST with no settle). The first out-of-band result clears locked in the same ADJUST cycle and applies the step.
- **Mid-operation exit:** enable or auto falling in any state returns the FSM to IDLE next cycle. The partial window is discarded, meas_count is kept, and locked is cleared.
- **Control priority:** resetn low overrides everything, then enable, then auto.

## Timing
- **Reset values:** trim=0, trim_level=0, meas_count=0, locked=0, busy=0, sat_hi=0, sat_lo=0. The synchronizer flops also clear.
- **Registered outputs:** all outputs are registered. trim and trim_level update on the clock edge ending ADJUST.
- **Manual mode:** trim follows man_level with 1-cycle latency.
- **osc_tgl to edge count:** 3 cycles.
- **Loop iteration:** 1 + SETTLE_CYC + 2^WIN_LOG2 cycles per step.
- **busy:** asserts the cycle after leaving IDLE and deasserts the cycle after entering IDLE.
- **osc_tgl rate:** must stay below clk/4 for the count to be exact.

## Structure
- **Package ring_osc_pkg:**
  - the state enum;
  - the function lvl2trim(level, NSTAGE) producing the thermometer vector;
  - the LW derivation helper.
- **Sub-module osc_edge_sync:** the synchronizer plus edge pulse.
- **Top:** FSM, counters, compare and level register.

## Test plan
- **Reset and manual mapping:** resetn=0 for 2 cycles leaves all outputs 0. Then auto=0 and man_level=15 with NSTAGE=13 give trim = {13'b0000000000011, 13'h1FFF} one cycle later.
- **Manual clamp:** man_level=31 gives trim_level=26 and trim all ones.
- **Lock from fast:** model the osc so count = 1000 − 20·level, with target=800 and tol=5. Level ramps 0 to 10, locked=1, meas_count=800, no level change for 3 further windows.
- **Saturation:** model a count stuck at 2000 with target=100. The level reaches 26, sat_hi=1, the level stays at 26, and locked=0.
- **Loss of lock:** while locked, shift the model so count = 850. In the next ADJUST, locked=0 and the level increments once.
- **Abort:** deassert enable mid-MEASURE. Next cycle state=IDLE, busy=0 one cycle later, meas_count unchanged, trim_level = man_level.
